// File: rtl/seven_seg_capture_if.sv
// Bus between a multiplexed 7-segment display driver (master) and the capture block (slave).
// The master drives the anode/cathode lines; the slave returns the decoded frame and status.
interface seven_seg_capture_if;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] digits;
  logic [3:0]  blank;
  logic        frame_valid;
  logic        bad_pattern;
  logic        stale;
  logic [3:0]  blink;

  modport master (
    output an, seg,
    input  digits, blank, frame_valid, bad_pattern, stale, blink
  );

  modport slave (
    input  an, seg,
    output digits, blank, frame_valid, bad_pattern, stale, blink
  );
endinterface

// File: rtl/seven_seg_capture.sv
// Snoops a 4-digit multiplexed 7-segment display and rebuilds the shown number as BCD digits.
// Optional macro SEG_CAPTURE_BLINK_EN adds per-digit blink detection on the blank flags.
module seven_seg_capture #(
  parameter int SETTLE_CYCLES = 8,
  parameter int STALE_CYCLES  = 200000
) (
  input  logic             clk,
  input  logic             reset,
  seven_seg_capture_if.slave bus
);

  typedef enum logic [1:0] {WAIT, SETTLE, HELD} state_t;

  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [23:0] STALE_TH    = 24'(STALE_CYCLES);
  localparam logic [23:0] STALE_MAX   = '1;

  state_t      state_reg, state_next;
  logic [3:0]  an_reg, an_prev_reg;
  logic [6:0]  seg_reg, seg_prev_reg;
  logic [7:0]  settle_cnt_reg;
  logic [23:0] stale_cnt_reg;
  logic [3:0]  seen_reg, seen_next;
  logic [15:0] shadow_val_reg;
  logic [3:0]  shadow_blank_reg;
  logic [15:0] digits_reg;
  logic [3:0]  blank_reg;
  logic        frame_valid_reg;
  logic        bad_pattern_reg;

  logic        anode_legal, sample_same, settle_done, frame_done;
  logic        cnt_load, cnt_inc, capture;
  logic [1:0]  dig_idx;
  logic [3:0]  dec_val;
  logic        dec_blank, dec_legal;
  logic [3:0]  slot_wr;

  assign anode_legal = $onehot(~an_reg);
  assign sample_same = (an_reg == an_prev_reg) && (seg_reg == seg_prev_reg);
  assign settle_done = sample_same && (settle_cnt_reg == SETTLE_LAST);
  assign frame_done  = (seen_reg == 4'hF);

  always_comb begin
    dig_idx = 2'd0;
    case (an_reg)
      4'b1101: dig_idx = 2'd1;
      4'b1011: dig_idx = 2'd2;
      4'b0111: dig_idx = 2'd3;
      default: dig_idx = 2'd0;
    endcase
  end

  // Cathodes are active-low: seg[0]=a .. seg[6]=g.
  always_comb begin
    dec_val   = 4'd0;
    dec_blank = 1'b0;
    dec_legal = 1'b1;
    case (seg_reg)
      7'h40: dec_val = 4'd0;
      7'h79: dec_val = 4'd1;
      7'h24: dec_val = 4'd2;
      7'h30: dec_val = 4'd3;
      7'h19: dec_val = 4'd4;
      7'h12: dec_val = 4'd5;
      7'h02: dec_val = 4'd6;
      7'h78: dec_val = 4'd7;
      7'h00: dec_val = 4'd8;
      7'h10: dec_val = 4'd9;
      7'h7F: dec_blank = 1'b1;
      default: dec_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= WAIT;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      WAIT:    if (anode_legal) state_next = SETTLE;
      SETTLE: begin
        if (!sample_same)     state_next = anode_legal ? SETTLE : WAIT;
        else if (settle_done) state_next = HELD;
      end
      HELD:    if (!sample_same) state_next = anode_legal ? SETTLE : WAIT;
      default: state_next = WAIT;
    endcase
  end

  always_comb begin
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    capture  = 1'b0;
    case (state_reg)
      WAIT:    cnt_load = anode_legal;
      SETTLE: begin
        if (!sample_same)     cnt_load = anode_legal;
        else if (settle_done) capture  = 1'b1;
        else                  cnt_inc  = 1'b1;
      end
      HELD:    cnt_load = !sample_same && anode_legal;
      default: ;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slot
      assign slot_wr[gi] = capture && dec_legal && (dig_idx == 2'(gi));
    end
  endgenerate

  // A frame completing while a new digit lands starts the next frame with just that digit.
  assign seen_next = (frame_done ? 4'h0 : seen_reg) | slot_wr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_reg           <= 4'hF;
      seg_reg          <= 7'h7F;
      an_prev_reg      <= 4'hF;
      seg_prev_reg     <= 7'h7F;
      settle_cnt_reg   <= 8'd0;
      stale_cnt_reg    <= 24'd0;
      seen_reg         <= 4'h0;
      shadow_val_reg   <= 16'h0000;
      shadow_blank_reg <= 4'hF;
      digits_reg       <= 16'h0000;
      blank_reg        <= 4'hF;
      frame_valid_reg  <= 1'b0;
      bad_pattern_reg  <= 1'b0;
    end else begin
      an_reg       <= bus.an;
      seg_reg      <= bus.seg;
      an_prev_reg  <= an_reg;
      seg_prev_reg <= seg_reg;
      if (cnt_load)     settle_cnt_reg <= 8'd1;
      else if (cnt_inc) settle_cnt_reg <= settle_cnt_reg + 8'd1;
      seen_reg        <= seen_next;
      bad_pattern_reg <= bad_pattern_reg | (capture & ~dec_legal);
      // A blank capture keeps the slot's last digit value and only raises its blank flag.
      for (int i = 0; i < 4; i++) begin
        if (slot_wr[i]) begin
          shadow_blank_reg[i] <= dec_blank;
          if (!dec_blank) shadow_val_reg[4*i +: 4] <= dec_val;
        end
      end
      frame_valid_reg <= frame_done;
      if (frame_done) begin
        digits_reg    <= shadow_val_reg;
        blank_reg     <= shadow_blank_reg;
        stale_cnt_reg <= 24'd0;
      end else if (stale_cnt_reg != STALE_MAX) begin
        stale_cnt_reg <= stale_cnt_reg + 24'd1;
      end
    end
  end

  assign bus.digits      = digits_reg;
  assign bus.blank       = blank_reg;
  assign bus.frame_valid = frame_valid_reg;
  assign bus.bad_pattern = bad_pattern_reg;
  assign bus.stale       = (stale_cnt_reg >= STALE_TH);

`ifdef SEG_CAPTURE_BLINK_EN
  logic [7:0] blank_hist_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blank_hist_reg <= 8'hFF;
    end else if (frame_done) begin
      for (int i = 0; i < 4; i++)
        blank_hist_reg[2*i +: 2] <= {blank_hist_reg[2*i], shadow_blank_reg[i]};
    end
  end

  generate
    for (gi = 0; gi < 4; gi++) begin : g_blink
      assign bus.blink[gi] = blank_hist_reg[2*gi+1] ^ blank_hist_reg[2*gi];
    end
  endgenerate
`else
  assign bus.blink = 4'b0000;
`endif

endmodule

// File: doc/seven_seg_capture.md
SEVEN_SEG_CAPTURE -- requirements
Module: seven_seg_capture

Interface
REQ-001 Parameter: SETTLE_CYCLES, default 8, consecutive identical samples required before a digit is accepted (legal range 2..255).
REQ-002 Parameter: STALE_CYCLES, default 200000, cycles without a completed frame before stale asserts (legal range 1..2^24-1).
REQ-003 Port: clk  input  1  sampling clock, rising edge.
REQ-004 Port: reset  input  1  reset, asynchronous, active-high.
REQ-005 Port: an  input  4  anode enables, active-low, an[i]=0 selects digit i.
REQ-006 Port: seg  input  7  cathodes, active-low, seg[0]=CA(a) .. seg[6]=CG(g).
REQ-007 Port: digits  output  16  captured frame, digits[4i+3:4i] = digit i value 0..9.
REQ-008 Port: blank  output  4  blank[i]=1 when digit i was captured with seg=7'h7F.
REQ-009 Port: frame_valid  output  1  one-cycle pulse when digits/blank update.
REQ-010 Port: bad_pattern  output  1  sticky flag, illegal segment pattern seen.
REQ-011 Port: stale  output  1  no frame completed within STALE_CYCLES.
REQ-012 Port: blink  output  4  digit blink flags (only with SEG_CAPTURE_BLINK_EN; tied 0 otherwise).

Function
REQ-013 The block SHALL register an and seg once per clk before any decode (one-stage input register).
REQ-014 A sample SHALL be legal only when exactly one bit of an is 0; any other anode pattern SHALL return the FSM to WAIT.
REQ-015 Decode table (seg -> value) SHALL be: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9 (hex), 7F->blank; every other pattern SHALL be illegal.
REQ-016 FSM states SHALL be WAIT, SETTLE, HELD.
REQ-017 WAIT -> SETTLE on a legal anode sample; settle counter loads 1.
REQ-018 In SETTLE, each sample equal to the previous (an and seg) SHALL increment the counter; any change SHALL reload it to 1 with the new sample (stay SETTLE if legal, else WAIT).
REQ-019 SETTLE -> HELD when the counter reaches SETTLE_CYCLES; on that cycle the decoded value SHALL be written to shadow slot i and seen[i] set.
REQ-020 If the accepted pattern is illegal, the block SHALL set bad_pattern, leave seen[i] clear, and still enter HELD.
REQ-021 HELD SHALL be left only on a change of an or seg (to SETTLE if legal, else WAIT); no second capture per dwell.
REQ-022 Re-capture of a digit already in seen SHALL overwrite its shadow slot.
REQ-023 When seen becomes 4'b1111, the next cycle SHALL copy shadow to digits/blank, pulse frame_valid for exactly one cycle, clear seen, and clear the stale counter.
REQ-024 Stale counter SHALL increment every cycle, saturate, and stale SHALL be 1 while counter >= STALE_CYCLES; frame_valid clears it.
REQ-025 Capture latency from first stable sample at the pins SHALL be SETTLE_CYCLES+1 cycles to shadow, +1 further cycle to frame_valid when completing a frame.
REQ-026 bad_pattern SHALL stay set until reset.
REQ-027 Reset mid-dwell SHALL discard partial frame (seen=0) with no frame_valid.

Reset
REQ-028 On reset: digits=16'h0000, blank=4'hF, frame_valid=0, bad_pattern=0, stale=0, blink=0, FSM=WAIT, seen=0, all counters 0.
REQ-029 Reset SHALL act asynchronously on assertion; outputs SHALL resume updating on the first clk edge after deassertion.

Configuration
REQ-030 Macro SEG_CAPTURE_BLINK_EN SHALL compile in blink detection; without it blink SHALL be constant 4'b0000 and no blink logic synthesised.
REQ-031 With SEG_CAPTURE_BLINK_EN: per digit, a 2-bit history of blank at each frame_valid; blink[i]=1 when the last two frames differ in blank[i], cleared after two consecutive frames with identical blank[i].

Verification
REQ-032 Scan "1234" (digits 0..3 = 4,3,2,1), 16 cycles per digit -> frame_valid pulse, digits=16'h1234, blank=0, bad_pattern=0.
REQ-033 Digit 2 shows seg=7F, others "5" -> digits[11:8] unchanged from prior frame value, blank=4'b0100.
REQ-034 Dwell of 5 cycles with SETTLE_CYCLES=8 -> no capture, seen unchanged, no frame_valid.
REQ-035 an=4'b0011 (two active) for 20 cycles -> FSM WAIT, nothing captured; seg=7'h55 held 10 cycles -> bad_pattern=1 sticky.
REQ-036 Stop scanning with STALE_CYCLES=100 -> stale=1 at cycle 100; resume full frame -> stale=0 the cycle after frame_valid.
REQ-037 Assert reset after 3 digits captured -> outputs at reset values, next full scan gives exactly one frame_valid after 4 digits.
